// File: rtl/lcd_step_counter.sv
// Position/step index generator for the LCD blink decoder: prescaled stepping,
// programmable wrap point, direction control, synchronous load and post-wrap hold.
module lcd_step_counter #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned STEP_HZ    = 2,
  parameter int unsigned POS_MAX    = 31,
  parameter int unsigned HOLD_STEPS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       dir,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] q,
  output logic       step,
  output logic       wrap,
  output logic       busy
);

  localparam int unsigned DIV    = CLK_HZ / STEP_HZ;
  localparam int unsigned CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned HOLD_W = (HOLD_STEPS > 0) ? $clog2(HOLD_STEPS + 1) : 1;
  localparam logic [7:0]  Q_MAX  = 8'(POS_MAX);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_d;
  logic [7:0]        q_d, load_q;
  logic              step_d, wrap_d, tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      hold_cnt <= '0;
      q        <= '0;
      step     <= 1'b0;
      wrap     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      hold_cnt <= hold_cnt_d;
      q        <= q_d;
      step     <= step_d;
      wrap     <= wrap_d;
      busy     <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    hold_cnt_d = hold_cnt;
    q_d        = q;
    step_d     = 1'b0;
    wrap_d     = 1'b0;
    load_q     = (load_val > Q_MAX) ? Q_MAX : load_val;
    tick       = (state != IDLE) && (cnt == CNT_W'(DIV - 1));

    if (!en) begin
      // Stop wins over any tick; a same-cycle load still lands in q.
      state_d = IDLE;
      cnt_d   = '0;
      if (load) q_d = load_q;
    end else if (load) begin
      q_d   = load_q;
      cnt_d = '0;
      if (state == HOLD) state_d = RUN;
    end else begin
      if (state != IDLE) cnt_d = tick ? '0 : cnt + CNT_W'(1);
      case (state)
        IDLE: state_d = RUN;
        RUN: if (tick) begin
          step_d = 1'b1;
          if (dir) begin
            if (q == Q_MAX) begin
              q_d    = '0;
              wrap_d = 1'b1;
            end else begin
              q_d = q + 8'd1;
            end
          end else begin
            if (q == 8'd0) begin
              q_d    = Q_MAX;
              wrap_d = 1'b1;
            end else begin
              q_d = q - 8'd1;
            end
          end
          if (wrap_d && (HOLD_STEPS > 0)) begin
            state_d    = HOLD;
            hold_cnt_d = '0;
          end
        end
        HOLD: if (tick) begin
          hold_cnt_d = hold_cnt + HOLD_W'(1);
          if (hold_cnt_d == HOLD_W'(HOLD_STEPS)) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
